// File: rtl/mem_loader.sv
// mem_loader: writer side of the feature/filter memory. Hunts for a sync byte,
// writes the 25 payload bytes in order, then verifies an 8-bit additive checksum.
module mem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         N_INPUT   = 16,
  parameter int         N_FILTER  = 9,
  parameter int         TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       load_done,
  output logic       load_err,
  output logic [1:0] err_code
);
  localparam int LAST = N_INPUT + N_FILTER - 1;
  localparam int IW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HUNT, LOAD, CSUM} state_t;

  state_t        state;
  state_t        state_next;
  logic [4:0]    cnt;
  logic [7:0]    sum;
  logic [IW-1:0] idle_cnt;
  logic          accept;
  logic          in_frame;
  logic          timed_out;

  assign in_ready = (state != IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign in_frame = (state == LOAD) || (state == CSUM);
  // The idle cycle that would bring the counter up to TIMEOUT ends the frame.
  assign timed_out = in_frame && !accept && (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = HUNT;
      HUNT: if (accept && in_data == SYNC_BYTE) state_next = LOAD;
      LOAD: begin
        if (timed_out)                       state_next = IDLE;
        else if (accept && cnt == 5'(LAST))  state_next = CSUM;
      end
      CSUM: if (timed_out || accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writes, checksum and status are registered so each appears the cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sum       <= '0;
      idle_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= '0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;

      if (accept || !in_frame || timed_out) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + IW'(1);

      case (state)
        HUNT: begin
          if (accept && in_data == SYNC_BYTE) begin
            cnt <= '0;
            sum <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt;
            wr_data <= in_data;
            sum     <= sum + in_data;
            cnt     <= cnt + 5'd1;
          end
        end
        CSUM: begin
          if (accept) begin
            if (in_data == sum) begin
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
              err_code <= 2'd1;
            end
          end
        end
        default: ;
      endcase

      if (timed_out) begin
        load_err <= 1'b1;
        err_code <= 2'd2;
      end
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed frames against a queue-based model of the loader,
// compared on every falling edge, plus hand-computed expectations per test.
module tb_mem_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       load_done;
  logic       load_err;
  logic [1:0] err_code;

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit         m_armed = 1'b0;
  bit         m_synced = 1'b0;
  int         m_idle = 0;
  logic [7:0] m_payload[$];
  logic       e_wr_en = 1'b0;
  logic       e_done = 1'b0;
  logic       e_err = 1'b0;
  logic [4:0] e_addr = '0;
  logic [7:0] e_data = '0;
  logic [1:0] e_code = '0;

  logic [12:0] wr_log[$];
  int          done_cnt = 0;
  int          err_cnt = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: the payload is a queue, the checksum is recomputed from it.
  task automatic model_step();
    logic [7:0] s;
    if (rst) begin
      m_armed = 1'b0; m_synced = 1'b0; m_idle = 0; m_payload.delete();
      e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_addr = '0; e_data = '0; e_code = '0;
    end else begin
      e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (!m_armed) begin
        if (start) begin
          m_armed = 1'b1;
          m_synced = 1'b0;
        end
      end else if (!m_synced) begin
        if (in_valid && in_data == 8'hA5) begin
          m_synced = 1'b1;
          m_payload.delete();
          m_idle = 0;
        end
      end else if (in_valid) begin
        m_idle = 0;
        if (m_payload.size() < 25) begin
          m_payload.push_back(in_data);
          e_wr_en = 1'b1;
          e_addr = 5'(m_payload.size() - 1);
          e_data = in_data;
        end else begin
          s = 8'h00;
          foreach (m_payload[i]) s += m_payload[i];
          if (in_data == s) e_done = 1'b1;
          else begin
            e_err = 1'b1;
            e_code = 2'd1;
          end
          m_armed = 1'b0;
        end
      end else begin
        m_idle++;
        if (m_idle == 1023) begin
          e_err = 1'b1;
          e_code = 2'd2;
          m_armed = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check_output("in_ready", 32'(in_ready), 32'(m_armed));
    check_output("busy", 32'(busy), 32'(m_armed));
    check_output("wr_en", 32'(wr_en), 32'(e_wr_en));
    check_output("wr_addr", 32'(wr_addr), 32'(e_addr));
    check_output("wr_data", 32'(wr_data), 32'(e_data));
    check_output("load_done", 32'(load_done), 32'(e_done));
    check_output("load_err", 32'(load_err), 32'(e_err));
    check_output("err_code", 32'(err_code), 32'(e_code));
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (load_done) done_cnt++;
    if (load_err) err_cnt++;
  end

  task automatic apply_stimulus(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    start = s;
    in_valid = v;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] chk);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 1; i <= 25; i++) apply_stimulus(1'b0, 1'b1, 8'(i));
    apply_stimulus(1'b0, 1'b1, chk);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_counting_log(input string name);
    for (int i = 0; i < wr_log.size(); i++)
      check_output(name, 32'(wr_log[i]), 32'({5'(i), 8'(i + 1)}));
  endtask

  logic [7:0] pay[25];
  logic [7:0] chk4;

  initial begin
    #2 rst = 1'b1;
    #1;
    check_output("reset wr_en", 32'(wr_en), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset in_ready", 32'(in_ready), 32'd0);
    check_output("reset load_done", 32'(load_done), 32'd0);
    check_output("reset load_err", 32'(load_err), 32'd0);
    check_output("reset err_code", 32'(err_code), 32'd0);
    check_output("reset wr_addr", 32'(wr_addr), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    $display("[TB] test 1: good frame back-to-back");
    clear_logs();
    send_frame(8'h45);
    check_output("t1 writes", 32'(wr_log.size()), 32'd25);
    check_counting_log("t1 write");
    check_output("t1 done", 32'(done_cnt), 32'd1);
    check_output("t1 err", 32'(err_cnt), 32'd0);
    check_output("t1 busy", 32'(busy), 32'd0);

    $display("[TB] test 2: bad checksum");
    clear_logs();
    send_frame(8'h44);
    check_output("t2 writes", 32'(wr_log.size()), 32'd25);
    check_output("t2 done", 32'(done_cnt), 32'd0);
    check_output("t2 err", 32'(err_cnt), 32'd1);
    check_output("t2 err_code", 32'(err_code), 32'd1);

    $display("[TB] test 3: junk before sync, then timeout");
    clear_logs();
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h7F);
    apply_stimulus(1'b0, 1'b1, 8'hA5);
    apply_stimulus(1'b0, 1'b1, 8'h11);
    apply_stimulus(1'b0, 1'b1, 8'h22);
    apply_stimulus(1'b0, 1'b1, 8'h33);
    repeat (1022) apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("t3 no early err", 32'(err_cnt), 32'd0);
    check_output("t3 busy before timeout", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("t3 load_err", 32'(load_err), 32'd1);
    check_output("t3 err_code", 32'(err_code), 32'd2);
    check_output("t3 in_ready", 32'(in_ready), 32'd0);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("t3 writes", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check_output("t3 first write", 32'(wr_log[0]), 32'h011);
      check_output("t3 last write", 32'(wr_log[2]), 32'h233);
    end
    check_output("t3 err count", 32'(err_cnt), 32'd1);

    $display("[TB] test 4: in_valid toggling every cycle");
    clear_logs();
    chk4 = 8'h00;
    for (int i = 0; i < 25; i++) begin
      pay[i] = 8'(i * 37 + 5);
      if (i == 3) pay[i] = 8'hA5;
      chk4 += pay[i];
    end
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 25; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'hFF);
      apply_stimulus(1'b0, 1'b1, pay[i]);
    end
    apply_stimulus(1'b0, 1'b0, 8'hFF);
    apply_stimulus(1'b0, 1'b1, chk4);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("t4 writes", 32'(wr_log.size()), 32'd25);
    for (int i = 0; i < wr_log.size(); i++)
      check_output("t4 write", 32'(wr_log[i]), 32'({5'(i), pay[i]}));
    check_output("t4 done", 32'(done_cnt), 32'd1);
    check_output("t4 err", 32'(err_cnt), 32'd0);

    $display("[TB] test 5: reset mid-frame");
    clear_logs();
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 1; i <= 10; i++) apply_stimulus(1'b0, 1'b1, 8'(i));
    rst = 1'b1;
    #1;
    check_output("t5 wr_en", 32'(wr_en), 32'd0);
    check_output("t5 busy", 32'(busy), 32'd0);
    check_output("t5 in_ready", 32'(in_ready), 32'd0);
    check_output("t5 err_code", 32'(err_code), 32'd0);
    check_output("t5 wr_addr", 32'(wr_addr), 32'd0);
    check_output("t5 wr_data", 32'(wr_data), 32'd0);
    #1 rst = 1'b0;
    check_output("t5 writes before reset", 32'(wr_log.size()), 32'd9);
    clear_logs();
    send_frame(8'h45);
    check_output("t5 reload writes", 32'(wr_log.size()), 32'd25);
    check_counting_log("t5 write");
    check_output("t5 done", 32'(done_cnt), 32'd1);

    $display("[TB] test 6: start while busy, valid while idle");
    clear_logs();
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b1, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hA5);
    for (int i = 1; i <= 25; i++) apply_stimulus(i == 5, 1'b1, 8'(i));
    apply_stimulus(1'b0, 1'b1, 8'h45);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("t6 writes", 32'(wr_log.size()), 32'd25);
    check_counting_log("t6 write");
    check_output("t6 done", 32'(done_cnt), 32'd1);
    check_output("t6 busy", 32'(busy), 32'd0);
    clear_logs();
    repeat (4) apply_stimulus(1'b0, 1'b1, 8'hA5);
    check_output("t6 idle writes", 32'(wr_log.size()), 32'd0);
    check_output("t6 idle in_ready", 32'(in_ready), 32'd0);
    check_output("t6 idle busy", 32'(busy), 32'd0);
    check_output("t6 idle done", 32'(done_cnt), 32'd0);
    apply_stimulus(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
